// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: shared types and defaults for the program counter unit.
//   pc_sel_t      - next-pc source select driven by control_unit
//   PC_ADDR_WIDTH - default width of pc, jump targets and return addresses
package pc_unit_pkg;

  localparam int unsigned PC_ADDR_WIDTH = 16;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_JUMP   = 2'b01,
    PC_RETURN = 2'b10,
    PC_BRANCH = 2'b11
  } pc_sel_t;

endpackage

// File: rtl/return_address_stack.sv
// return_address_stack: LIFO of return addresses with overflow/underflow flag.
//   clk, reset  - clock, asynchronous active-high reset (pointer and flag only)
//   push        - write push_data above the current top
//   pop         - discard the current top
//   push & pop  - replace the current top (plain push when empty)
//   push_data   - address to store
//   top         - entry below the pointer, 0 when empty
//   empty, full - occupancy decoded from the pointer
//   error       - sticky: push while full or pop while empty
module return_address_stack
  import pc_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = PC_ADDR_WIDTH,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] top,
  output logic                  empty,
  output logic                  full,
  output logic                  error
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [ADDR_WIDTH-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_next;
  logic [IDX_W-1:0]      top_idx;
  logic [IDX_W-1:0]      wr_idx;
  logic                  do_write;
  logic                  err_set;

  assign top_idx = IDX_W'(ptr - PTR_W'(1));
  assign empty   = (ptr == '0);
  assign full    = (ptr == PTR_W'(STACK_DEPTH));
  assign top     = empty ? '0 : mem[top_idx];

  always_comb begin
    ptr_next = ptr;
    wr_idx   = ptr[IDX_W-1:0];
    do_write = 1'b0;
    err_set  = 1'b0;
    unique case ({push, pop})
      2'b10: begin
        if (full) begin
          err_set = 1'b1;
        end else begin
          do_write = 1'b1;
          ptr_next = ptr + PTR_W'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          err_set = 1'b1;
        end else begin
          ptr_next = ptr - PTR_W'(1);
        end
      end
      2'b11: begin
        // Replace the top in place; an empty stack has no top, so push instead.
        do_write = 1'b1;
        if (empty) begin
          ptr_next = ptr + PTR_W'(1);
        end else begin
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      error <= 1'b0;
    end else begin
      ptr <= ptr_next;
      if (err_set) begin
        error <= 1'b1;
      end
    end
  end

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/program_counter_unit.sv
// program_counter_unit: program counter register, next-pc mux and return stack.
//   clk, reset           - clock, asynchronous active-high reset
//   pc_increment_control - advance in SEQ mode (0 holds pc)
//   pc_control           - next-pc select (pc_sel_t)
//   branch, alu_zero     - branch taken when both set in BRANCH mode
//   stack_write_enable   - push pc+1 (call)
//   stack_control        - pop top of stack (return)
//   jump_target          - immediate target for JUMP / taken BRANCH
//   pc                   - registered program counter
//   return_address       - current top of stack, 0 when empty
//   stack_empty/full     - stack occupancy
//   stack_error          - sticky overflow/underflow flag
module program_counter_unit
  import pc_unit_pkg::*;
#(
  parameter int unsigned          ADDR_WIDTH   = PC_ADDR_WIDTH,
  parameter int unsigned          STACK_DEPTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  pc_increment_control,
  input  logic [1:0]            pc_control,
  input  logic                  branch,
  input  logic                  alu_zero,
  input  logic                  stack_write_enable,
  input  logic                  stack_control,
  input  logic [ADDR_WIDTH-1:0] jump_target,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] return_address,
  output logic                  stack_empty,
  output logic                  stack_full,
  output logic                  stack_error
);

  pc_sel_t               pc_sel;
  logic [ADDR_WIDTH-1:0] pc_plus_one;
  logic [ADDR_WIDTH-1:0] pc_next;

  assign pc_sel      = pc_sel_t'(pc_control);
  assign pc_plus_one = pc + ADDR_WIDTH'(1);

  return_address_stack #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (stack_write_enable),
    .pop      (stack_control),
    .push_data(pc_plus_one),
    .top      (return_address),
    .empty    (stack_empty),
    .full     (stack_full),
    .error    (stack_error)
  );

  always_comb begin
    pc_next = pc;
    unique case (pc_sel)
      PC_SEQ:    pc_next = pc_increment_control ? pc_plus_one : pc;
      PC_JUMP:   pc_next = jump_target;
      PC_RETURN: pc_next = stack_empty ? pc : return_address;
      PC_BRANCH: pc_next = (branch && alu_zero) ? jump_target : pc_plus_one;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_VECTOR;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: doc/program_counter_unit.md
Name: program_counter_unit

Overview:
Holds the program counter and a hardware return-address stack. It sits directly downstream of control_unit and consumes its PC and stack control outputs each cycle. Its registered pc output addresses instruction memory, which yields the next opcode for control_unit. It resolves sequential flow, jumps, calls, returns and conditional branches, using the ALU zero flag for branches.

Parameters:
ADDR_WIDTH, 16, width of pc and all target and return addresses
STACK_DEPTH, 8, number of return-address entries (power of 2, at least 2)
RESET_VECTOR, 0, pc value loaded on reset

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
pc_increment_control  input  1  1 = advance in sequential mode; 0 = hold pc (halt/stall)
pc_control  input  2  next-pc select: 00 SEQ, 01 JUMP, 10 RETURN, 11 BRANCH
branch  input  1  branch instruction qualifier from control_unit
alu_zero  input  1  ALU zero flag for the current instruction
stack_write_enable  input  1  push pc+1 (call)
stack_control  input  1  pop top of stack (return)
jump_target  input  ADDR_WIDTH  immediate target from instruction field
pc  output  ADDR_WIDTH  current program counter (registered)
return_address  output  ADDR_WIDTH  top of stack; 0 when empty
stack_empty  output  1  no entries held
stack_full  output  1  STACK_DEPTH entries held
stack_error  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (asynchronous, any time, including mid-call or mid-return):
  - pc=RESET_VECTOR, stack pointer=0, stack_empty=1, stack_full=0, stack_error=0, return_address=0.
  - Stack RAM contents are not reset.
- pc_next selection, registered on the next clk edge (1-cycle latency, no bubbles):
  - SEQ: pc+1 if pc_increment_control=1, else pc.
  - JUMP: jump_target.
  - RETURN: top of stack when not empty. When empty, pc holds.
  - BRANCH: jump_target if (branch & alu_zero), else pc+1.
- pc arithmetic is modulo 2^ADDR_WIDTH. pc=all-ones with SEQ gives 0, with no flag.
- Push (stack_write_enable=1, pop not asserted):
  - Writes pc+1 (wrapped) at the stack pointer and increments the pointer.
  - When full, the push is dropped, the pointer is unchanged and stack_error is set.
- Pop (stack_control=1, push not asserted):
  - Decrements the pointer.
  - When empty, the pointer is unchanged and stack_error is set.
- Push and pop in the same cycle:
  - The top entry is replaced with pc+1 and the pointer is unchanged.
  - On an empty stack this is a plain push and does not flag.
- RETURN uses the pre-pop top value. Pop without RETURN discards the top entry.
- return_address is combinational from the current top: entry[pointer-1], or 0 when empty.
- stack_full and stack_empty decode combinationally from the registered pointer.
- The pointer has width $clog2(STACK_DEPTH)+1.
- stack_error is cleared only by reset.

Decomposition:
- Package pc_unit_pkg holds:
  - enum pc_sel_t {PC_SEQ=2'b00, PC_JUMP=2'b01, PC_RETURN=2'b10, PC_BRANCH=2'b11}
  - the ADDR_WIDTH default
- One sub-module, return_address_stack: the LIFO with push, pop, replace, full, empty, error and top.
- program_counter_unit instantiates it and owns the pc register and the next-pc mux.

Test Plan:
- Reset, then 5 cycles of SEQ with increment=1 -> pc sequence 0,1,2,3,4,5; return_address=0; stack_empty=1. Assert reset mid-cycle -> pc=0 immediately.
- At pc=4: JUMP with target 0x0040 plus push -> next pc=0x0040, return_address=5. Then RETURN plus pop -> pc=5, stack_empty=1, stack_error=0.
- BRANCH target 0x0100 at pc=0x10: branch=1, alu_zero=0 -> pc=0x11. Then branch=1, alu_zero=1 -> pc=0x0100. Then branch=0, alu_zero=1 -> pc=0x0101.
- 8 pushes -> stack_full=1, stack_error=0. 9th push -> dropped, stack_error=1, return_address unchanged. 8 pops then RETURN on empty -> pc holds, stack_error stays 1 until reset.
- Push and pop together at pc=0x20 with top=0x7 -> top becomes 0x21, depth unchanged, pc follows pc_control.
- pc=0xFFFF, SEQ -> pc=0x0000. pc_increment_control=0 for 3 cycles -> pc constant.
